// File: rtl/ifu_pkg.sv
// Shared fetch-unit types and constants.
package ifu_pkg;

  localparam int ISA_WIDTH = 32;
  localparam int INST_WIDTH = ISA_WIDTH;

  localparam logic [ISA_WIDTH-1:0] RESET_PC_DEF =
    32'h8000_0000;

  typedef struct packed {
    logic [ISA_WIDTH-1:0]  pc;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

  // Counters must hold the value DEPTH itself.
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain two-operand adder, result wraps modulo 2^W.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a one-cycle
// flush; rdata_o is the current head (no fall-through).
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q
            + (AW+1)'(do_push)
            - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Decoupled fetch front end: PC owner, credit-limited imem
// requests, tag FIFO for in-flight PCs, entry FIFO to decode.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              XLEN     = ISA_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_snpc
);

  localparam int CW = fq_cnt_w(FQ_DEPTH);
  localparam int EW = $bits(fq_entry_t);

  logic [XLEN-1:0] fpc_q;
  logic [XLEN-1:0] fpc_d;
  logic [XLEN-1:0] fpc_inc;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] snpc_sum;
  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   drop_d;
  logic [CW-1:0]   live;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            rst_done_q;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_drop;
  logic            deq;
  fq_entry_t       push_e;
  fq_entry_t       head_e;

  assign redir_pc = redirect_pc & ~XLEN'(3);

  // Credits cover buffered, live and to-be-dropped slots.
  assign used = {1'b0, count}
              + {1'b0, live}
              + {1'b0, drop_q};

  assign imem_req_valid = rst_done_q
                        & ~redirect_valid
                        & (used < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fpc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_live = imem_rsp_valid & (drop_q == '0);
  assign deq      = inst_valid & inst_ready;

  adder #(.W(XLEN)) u_fpc_inc (
    .a_i   (fpc_q),
    .b_i   (XLEN'(4)),
    .sum_o (fpc_inc)
  );

  adder #(.W(XLEN)) u_snpc_inc (
    .a_i   (head_e.pc),
    .b_i   (XLEN'(4)),
    .sum_o (snpc_sum)
  );

  sync_fifo #(.W(XLEN), .DEPTH(FQ_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .pop_i   (rsp_live),
    .wdata_i (fpc_q),
    .rdata_o (tag_head),
    .count_o (live)
  );

  assign push_e.pc   = tag_head;
  assign push_e.inst = imem_rsp_data;

  sync_fifo #(.W(EW), .DEPTH(FQ_DEPTH)) u_entry_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_live),
    .pop_i   (deq),
    .wdata_i (push_e),
    .rdata_o (head_e),
    .count_o (count)
  );

  always_comb begin
    fpc_d = fpc_q;
    unique case (1'b1)
      redirect_valid: fpc_d = redir_pc;
      req_fire:       fpc_d = fpc_inc;
      default:        fpc_d = fpc_q;
    endcase
  end

  // On redirect every live request becomes one to drop.
  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = drop_q + live
             - CW'(imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q      <= RESET_PC;
      drop_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      drop_q     <= drop_d;
      rst_done_q <= 1'b1;
    end
  end

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head_e.inst : '0;
  assign inst_pc    = inst_valid ? head_e.pc : '0;
  assign inst_snpc  = inst_valid ? snpc_sum : '0;

endmodule
